// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetch PC generation with BTB-steered lane masking,
// a one-cycle in-flight stage that waits for the instruction memory response,
// and a circular queue of fetch bundles that feeds decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the in-flight
// bundle straight to the outputs when the queue is empty.
module instruction_fetch_queue #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           FETCH_WIDTH = 2,
   parameter int unsigned           QUEUE_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              imem_req_valid,
   output logic [ADDR_WIDTH-1:0]             imem_req_addr,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] imem_rsp_data,
   input  logic [FETCH_WIDTH-1:0]            pred_taken,
   input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] pred_target,
   input  logic                              redirect_valid,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] out_pc,
   output logic [FETCH_WIDTH*DATA_WIDTH-1:0] out_instr,
   output logic [FETCH_WIDTH-1:0]            out_lane_valid,
   output logic [FETCH_WIDTH-1:0]            out_pred_taken,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] out_pred_target
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] BUNDLE_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);

   // fetch PC and in-flight stage
   logic [ADDR_WIDTH-1:0]             fetch_pc_q, fetch_pc_d;
   logic [FETCH_WIDTH-1:0]            req_mask;
   logic                              taken_found;
   logic                              s1_valid_q;
   logic [ADDR_WIDTH-1:0]             s1_pc_q;
   logic [FETCH_WIDTH-1:0]            s1_mask_q;
   logic [FETCH_WIDTH-1:0]            s1_taken_q;
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] s1_target_q;
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] s1_lane_pc;

   // bundle queue storage and pointers
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] q_pc_q     [QUEUE_DEPTH];
   logic [FETCH_WIDTH*DATA_WIDTH-1:0] q_instr_q  [QUEUE_DEPTH];
   logic [FETCH_WIDTH-1:0]            q_mask_q   [QUEUE_DEPTH];
   logic [FETCH_WIDTH-1:0]            q_taken_q  [QUEUE_DEPTH];
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] q_target_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]                  head_q, tail_q;
   logic [CNT_W-1:0]                  count_q;

   logic [CNT_W:0] occupancy;
   logic           queue_nonempty;
   logic           bypass;
   logic           push;
   logic           pop;

   // A request is only issued if the bundle it produces is guaranteed a slot;
   // a pop in the same cycle is deliberately not credited.
   assign occupancy      = {1'b0, count_q} + (CNT_W+1)'(s1_valid_q);
   assign queue_nonempty = (count_q != '0);
   assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
   assign imem_req_addr  = fetch_pc_q;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = s1_valid_q && !queue_nonempty;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = !rst && (queue_nonempty || bypass);
   assign pop       = !rst && !redirect_valid && out_ready && queue_nonempty;
   // a bypassed bundle that decode accepts never enters the queue
   assign push      = !rst && !redirect_valid && s1_valid_q && !(bypass && out_ready);

   // next fetch PC and lane mask: lanes up to and including the first taken one
   always_comb begin
      fetch_pc_d  = fetch_pc_q + BUNDLE_BYTES;
      req_mask    = '0;
      taken_found = 1'b0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         if (!taken_found) begin
            req_mask[i] = 1'b1;
            if (pred_taken[i]) begin
               taken_found = 1'b1;
               fetch_pc_d  = pred_target[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end
      end
   end

   // per-lane PCs of the in-flight bundle
   always_comb begin
      s1_lane_pc = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         s1_lane_pc[i*ADDR_WIDTH +: ADDR_WIDTH] = s1_pc_q + ADDR_WIDTH'(4 * i);
      end
   end

   // head bundle selection, from the in-flight stage when bypassing
   always_comb begin
      if (bypass) begin
         out_pc          = s1_lane_pc;
         out_instr       = imem_rsp_data;
         out_lane_valid  = s1_mask_q;
         out_pred_taken  = s1_taken_q;
         out_pred_target = s1_target_q;
      end else begin
         out_pc          = q_pc_q[head_q];
         out_instr       = q_instr_q[head_q];
         out_lane_valid  = q_mask_q[head_q];
         out_pred_taken  = q_taken_q[head_q];
         out_pred_target = q_target_q[head_q];
      end
   end

   // control state: fetch PC, in-flight valid, queue pointers; redirect beats push/pop/request
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         s1_valid_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else if (redirect_valid) begin
         fetch_pc_q <= redirect_pc;
         s1_valid_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= imem_req_valid;
         if (imem_req_valid) begin
            fetch_pc_q <= fetch_pc_d;
         end
         if (push) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // in-flight payload captured alongside each request
   always_ff @(posedge clk) begin
      if (imem_req_valid) begin
         s1_pc_q     <= fetch_pc_q;
         s1_mask_q   <= req_mask;
         s1_taken_q  <= pred_taken;
         s1_target_q <= pred_target;
      end
   end

   // queue storage write at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc_q[tail_q]     <= s1_lane_pc;
         q_instr_q[tail_q]  <= imem_rsp_data;
         q_mask_q[tail_q]   <= s1_mask_q;
         q_taken_q[tail_q]  <= s1_taken_q;
         q_target_q[tail_q] <= s1_target_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue (FETCH_WIDTH=2, QUEUE_DEPTH=4).
// Directed scenarios followed by random traffic, all checked against a
// bundle-level queue model. Honours FETCH_QUEUE_BYPASS_EN if defined.
module tb_instruction_fetch_queue;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic [63:0] imem_rsp_data;
   logic [1:0]  pred_taken;
   logic [63:0] pred_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [63:0] out_instr;
   logic [1:0]  out_lane_valid;
   logic [1:0]  out_pred_taken;
   logic [63:0] out_pred_target;

   instruction_fetch_queue #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .FETCH_WIDTH(2),
      .QUEUE_DEPTH(4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_data  (imem_rsp_data),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_lane_valid (out_lane_valid),
      .out_pred_taken (out_pred_taken),
      .out_pred_target(out_pred_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] ins;
      logic [1:0]  lv;
      logic [1:0]  tk;
      logic [63:0] tg;
   } bundle_t;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // reference model state
   logic [31:0] m_fpc;
   logic        m_s1v;
   bundle_t     m_s1;
   bundle_t     m_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // one clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [1:0] pt, input logic [63:0] ptg);
      bundle_t     hd;
      bundle_t     s1b;
      logic        e_req;
      logic        e_byp;
      logic        e_ov;
      int          k;
      logic [31:0] p0;
      logic [31:0] p1;
      @(negedge clk);
      rst            = r;
      redirect_valid = rd;
      redirect_pc    = rpc;
      out_ready      = rdy;
      pred_taken     = pt;
      pred_target    = ptg;
      if (m_s1v) imem_rsp_data = {mem_word(m_s1.pc[63:32]), mem_word(m_s1.pc[31:0])};
      else       imem_rsp_data = {$urandom, $urandom};
      #1;
      s1b     = m_s1;
      s1b.ins = imem_rsp_data;
      e_req   = !r && !rd && ((m_q.size() + (m_s1v ? 1 : 0)) < 4);
      e_byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      e_byp   = !r && m_s1v && (m_q.size() == 0);
`endif
      e_ov    = !r && ((m_q.size() != 0) || e_byp);
      chk("req_valid", 64'(imem_req_valid), 64'(e_req));
      if (e_req) chk("req_addr", 64'(imem_req_addr), 64'(m_fpc));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) begin
         hd = (m_q.size() != 0) ? m_q[0] : s1b;
         chk("out_pc", out_pc, hd.pc);
         chk("out_instr", out_instr, hd.ins);
         chk("out_lane_valid", 64'(out_lane_valid), 64'(hd.lv));
         chk("out_pred_taken", 64'(out_pred_taken), 64'(hd.tk));
         chk("out_pred_target", out_pred_target, hd.tg);
      end
      if (r) begin
         m_fpc = 32'h0;
         m_s1v = 1'b0;
         m_q.delete();
      end else if (rd) begin
         m_fpc = rpc;
         m_s1v = 1'b0;
         m_q.delete();
      end else begin
         if (e_ov && rdy && (m_q.size() != 0)) void'(m_q.pop_front());
         if (m_s1v && !(e_byp && rdy)) m_q.push_back(s1b);
         if (e_req) begin
            k = -1;
            for (int i = 1; i >= 0; i--) if (pt[i]) k = i;
            p0 = m_fpc;
            p1 = m_fpc + 32'd4;
            m_s1.pc  = {p1, p0};
            m_s1.ins = '0;
            m_s1.tk  = pt;
            m_s1.tg  = ptg;
            if (k < 0) begin
               m_s1.lv = 2'b11;
               m_fpc   = m_fpc + 32'd8;
            end else begin
               m_s1.lv = 2'((3'd2 << k) - 3'd1);
               m_fpc   = ptg[k*32 +: 32];
            end
            m_s1v = 1'b1;
         end else begin
            m_s1v = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy, 2'b00, 64'h0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 2'b00, 64'h0);
   endtask

   initial begin
      logic [31:0] t0;
      logic [31:0] t1;
      logic [31:0] t2;
      logic [1:0]  pt;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      pred_taken = '0; pred_target = '0; imem_rsp_data = '0;
      m_fpc = '0; m_s1v = 1'b0; m_s1 = '0;

      // reset state, then streaming with no predictions
      do_reset(3);
      idle(8, 1'b1);

      // lane-0 taken at the second request (address 0x8)
      do_reset(1);
      idle(1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 2'b01, {32'h0000_0500, 32'h0000_0100});
      idle(5, 1'b1);

      // backpressure from reset fills the queue, then drain
      do_reset(1);
      idle(8, 1'b0);
      idle(10, 1'b1);

      // redirect with three queued bundles and one in flight
      do_reset(1);
      idle(4, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 2'b00, 64'h0);
      idle(6, 1'b1);

      // redirect coinciding with a pop
      idle(2, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 2'b00, 64'h0);
      idle(4, 1'b1);

      // lane-1 taken at the top of the address space, then plain wrap
      step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 2'b00, 64'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 2'b10, {32'h0000_0040, 32'h0000_0900});
      idle(4, 1'b1);
      step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 2'b00, 64'h0);
      idle(5, 1'b1);

      // mid-operation reset discards everything
      idle(3, 1'b0);
      do_reset(1);
      idle(4, 1'b1);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         t0 = $urandom;
         t1 = $urandom;
         t2 = $urandom;
         pt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 24) == 0),
              {t0[31:2], 2'b00},
              ($urandom_range(0, 2) != 0),
              pt,
              {t1[31:2], 2'b00, t2[31:2], 2'b00});
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
